// File: rtl/inst_fetch_if.sv
// Handshake bundle between the fetch stage, instruction memory, branch resolution and decode.
// The master modport is the fetch stage; the slave modport is everything around it.
interface inst_fetch_if;
   logic        fetch_en;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd;
   logic [31:0] cmd_pc;

   modport master (
      input  fetch_en, redirect_valid, redirect_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, cmd_ready,
      output imem_req_valid, imem_req_addr, cmd_valid, cmd, cmd_pc
   );

   modport slave (
      output fetch_en, redirect_valid, redirect_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, cmd_ready,
      input  imem_req_valid, imem_req_addr, cmd_valid, cmd, cmd_pc
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: credit-limited word requests, in-order response FIFO, redirect flush.
// Define IFU_PERF_CNT_EN to add the stall_cnt / inst_cnt performance counter outputs.
module inst_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus_io
`ifdef IFU_PERF_CNT_EN
   ,
   output logic [31:0]  stall_cnt,
   output logic [31:0]  inst_cnt
`endif
);
   localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, iss_ptr_q, iss_ptr_d;
   logic [31:0]   data_mem [FIFO_DEPTH];
   logic [31:0]   pc_mem   [FIFO_DEPTH];

   logic          req_fire, rsp_ok, push, pop, redirect;
   logic [CW-1:0] outst_next;

   assign redirect   = bus_io.redirect_valid;
   // Credits cover both buffered and in-flight words, so every response has a slot waiting.
   assign bus_io.imem_req_valid = (state_q == RUN) && ((count_q + outst_q) < DEPTH_C);
   assign bus_io.imem_req_addr  = fetch_pc_q;
   assign req_fire   = bus_io.imem_req_valid & bus_io.imem_req_ready;
   assign rsp_ok     = bus_io.imem_rsp_valid && (outst_q != '0);
   assign pop        = bus_io.cmd_valid & bus_io.cmd_ready;
   assign push       = rsp_ok && (discard_q == '0) && !redirect;
   assign outst_next = outst_q + CW'(req_fire) - CW'(rsp_ok);

   assign bus_io.cmd_valid = (count_q != '0);
   assign bus_io.cmd       = bus_io.cmd_valid ? data_mem[rd_ptr_q] : '0;
   assign bus_io.cmd_pc    = bus_io.cmd_valid ? pc_mem[rd_ptr_q]   : '0;

   // NOTE: every variable gets its hold value first so no path through this block infers a latch.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      outst_d    = outst_next;
      discard_d  = discard_q;
      count_d    = count_q + CW'(push) - CW'(pop);
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      iss_ptr_d  = iss_ptr_q;

      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         iss_ptr_d  = iss_ptr_q + PW'(1);
      end
      if (push)                         wr_ptr_d  = wr_ptr_q + PW'(1);
      if (pop)                          rd_ptr_d  = rd_ptr_q + PW'(1);
      if (rsp_ok && discard_q != '0)    discard_d = discard_q - CW'(1);

      unique case (state_q)
         IDLE:    if (bus_io.fetch_en) state_d = RUN;
         RUN:     if (!bus_io.fetch_en) state_d = IDLE;
         DRAIN:   if (discard_q == '0) state_d = bus_io.fetch_en ? RUN : IDLE;
         default: state_d = IDLE;
      endcase

      // Everything issued up to and including this cycle is stale; drop it as it returns.
      if (redirect) begin
         fetch_pc_d = bus_io.redirect_pc & ~32'h3;
         discard_d  = outst_next;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         iss_ptr_d  = '0;
         state_d    = (outst_next != '0) ? DRAIN : (bus_io.fetch_en ? RUN : IDLE);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         outst_q    <= '0;
         discard_q  <= '0;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         iss_ptr_q  <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         outst_q    <= outst_d;
         discard_q  <= discard_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         iss_ptr_q  <= iss_ptr_d;
      end
   end

   // NOTE: storage is not reset; count_q gates every read, and cmd/cmd_pc are forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (req_fire) pc_mem[iss_ptr_q]  <= fetch_pc_q;
      if (push)     data_mem[wr_ptr_q] <= bus_io.imem_rsp_data;
   end

`ifdef IFU_PERF_CNT_EN
   logic [31:0] stall_cnt_q, inst_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         inst_cnt_q  <= '0;
      end else begin
         if (bus_io.imem_req_valid && !bus_io.imem_req_ready && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (pop && inst_cnt_q != '1)
            inst_cnt_q <= inst_cnt_q + 32'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign inst_cnt  = inst_cnt_q;
`endif

   rsp_without_req_a : assert property (@(posedge clk) disable iff (rst)
      !(bus_io.imem_rsp_valid && (outst_q == '0)))
      else $error("inst_fetch: response with no request outstanding");

endmodule
